// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan controller.
//   - Active-low glyphs {dp,g,f,e,d,c,b,a} for decimal digits 0..9, blank, minus
//   - Number of scanned digits
//   - Conversion FSM state type
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_MINUS = 8'hBF;

    localparam logic [7:0] GLYPH_DIGIT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational BCD digit to active-low seven-segment glyph.
//   bcd   [3:0] in  : BCD digit; codes above 9 produce a blank glyph
//   glyph [7:0] out : {dp,g,f,e,d,c,b,a}, active low, dp always off
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = GLYPH_BLANK;
        if (bcd < 4'd10) begin
            glyph = GLYPH_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: converts a signed 8-bit value to sign + 3 BCD digits with a
// double-dabble FSM and scans them onto a 4-digit multiplexed display.
//   clk        in  : clock, rising edge
//   rst        in  : asynchronous active-high reset
//   load       in  : capture data (accepted only while busy=0)
//   data [7:0] in  : signed two's-complement value
//   busy       out : conversion in progress
//   seg  [7:0] out : active-low segments {dp,g,f,e,d,c,b,a}, registered
//   an   [3:0] out : active-low digit enables (0 ones,1 tens,2 hundreds,3 sign)
// Parameter SCAN_DIV: clk cycles per digit-scan step (2..2^20).
// Macro SEG_LZ_BLANK_EN: when defined, leading zeros of hundreds/tens are blanked.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam int unsigned IW = $clog2(NUM_DIGITS);

    state_t          state_q, state_d;
    logic [2:0]      step_q, step_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [11:0]     bcd_q, bcd_d;
    logic            sign_cap_q, sign_cap_d;
    logic [11:0]     disp_bcd_q, disp_bcd_d;
    logic            disp_sign_q, disp_sign_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [7:0]      seg_q, seg_d;

    logic [11:0]     bcd_adj;
    logic [19:0]     dd_next;
    logic [3:0]      sel_bcd;
    logic [7:0]      dec_glyph;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (load) state_d = ST_CONVERT;
            ST_CONVERT: if (step_q == 3'd7) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ST_CONVERT);
    end

    // ---------------- Double-dabble datapath ----------------
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        // Magnitude bits shift out of shreg's MSB into the BCD accumulator.
        dd_next = {bcd_adj, shreg_q} << 1;
    end

    always_comb begin
        step_d      = step_q;
        shreg_d     = shreg_q;
        bcd_d       = bcd_q;
        sign_cap_d  = sign_cap_q;
        disp_bcd_d  = disp_bcd_q;
        disp_sign_d = disp_sign_q;
        if (state_q == ST_IDLE) begin
            if (load) begin
                sign_cap_d = data[7];
                // -128 negates to 8'h80, which reads correctly as unsigned 128.
                shreg_d    = data[7] ? (~data + 8'd1) : data;
                bcd_d      = '0;
                step_d     = '0;
            end
        end else begin
            bcd_d   = dd_next[19:8];
            shreg_d = dd_next[7:0];
            step_d  = step_q + 3'd1;
            // Final step result goes straight to the display so all digits change together.
            if (step_q == 3'd7) begin
                disp_bcd_d  = dd_next[19:8];
                disp_sign_d = sign_cap_q;
            end
        end
    end

    // ---------------- Scan datapath ----------------
    always_comb begin
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
            idx_d   = idx_q;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    sel_bcd = disp_bcd_q[3:0];
            2'd1:    sel_bcd = disp_bcd_q[7:4];
            2'd2:    sel_bcd = disp_bcd_q[11:8];
            default: sel_bcd = 4'd0;
        endcase
    end

    seg_decode u_decode (
        .bcd   (sel_bcd),
        .glyph (dec_glyph)
    );

    always_comb begin
        an_d = ~(NUM_DIGITS'(1) << idx_q);
        if (idx_q == 2'd3) begin
            seg_d = disp_sign_q ? GLYPH_MINUS : GLYPH_BLANK;
        end else begin
            seg_d = dec_glyph;
        end
`ifdef SEG_LZ_BLANK_EN
        if (idx_q == 2'd2 && disp_bcd_q[11:8] == 4'd0) begin
            seg_d = GLYPH_BLANK;
        end
        if (idx_q == 2'd1 && disp_bcd_q[11:4] == 8'd0) begin
            seg_d = GLYPH_BLANK;
        end
`endif
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q      <= '0;
            shreg_q     <= '0;
            bcd_q       <= '0;
            sign_cap_q  <= 1'b0;
            disp_bcd_q  <= '0;
            disp_sign_q <= 1'b0;
            presc_q     <= '0;
            idx_q       <= '0;
            an_q        <= '1;
            seg_q       <= GLYPH_BLANK;
        end else begin
            step_q      <= step_d;
            shreg_q     <= shreg_d;
            bcd_q       <= bcd_d;
            sign_cap_q  <= sign_cap_d;
            disp_bcd_q  <= disp_bcd_d;
            disp_sign_q <= disp_sign_d;
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl with SCAN_DIV=4.
// Expected digits come from decimal arithmetic on the loaded value; expected
// scan position comes from a free-running cycle count since reset.
module tb_seg_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       load;
    logic [7:0] data;
    logic       busy;
    logic [7:0] seg;
    logic [3:0] an;

    int checks;
    int errors;
    int cyc;
    int disp_val;

    seg_scan_ctrl #(.SCAN_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (data),
        .busy (busy),
        .seg  (seg),
        .an   (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] exp_glyph(int d, int val);
        logic [7:0] tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        int mag;
        int h;
        int t;
        int o;
        logic [7:0] g;
        mag = (val < 0) ? -val : val;
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        case (d)
            0: g = tbl[o];
            1: begin
                g = tbl[t];
`ifdef SEG_LZ_BLANK_EN
                if (h == 0 && t == 0) g = 8'hFF;
`endif
            end
            2: begin
                g = tbl[h];
`ifdef SEG_LZ_BLANK_EN
                if (h == 0) g = 8'hFF;
`endif
            end
            default: g = (val < 0) ? 8'hBF : 8'hFF;
        endcase
        return g;
    endfunction

    function automatic logic [3:0] an_pattern(int d);
        logic [3:0] p;
        p = 4'b1111;
        p[d] = 1'b0;
        return p;
    endfunction

    task automatic check_digits(input string name);
        int n;
        for (int d = 0; d < 4; d++) begin
            n = 0;
            while (an !== an_pattern(d) && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (an !== an_pattern(d)) begin
                errors++;
                $display("FAIL %s digit%0d scan timeout: an=%b required %b", name, d, an, an_pattern(d));
            end else if (seg !== exp_glyph(d, disp_val)) begin
                errors++;
                $display("FAIL %s digit%0d seg: got %h required %h (value %0d)",
                         name, d, seg, exp_glyph(d, disp_val), disp_val);
            end
        end
    endtask

    // Issues a load at the next edge while scrambling data/load during conversion.
    task automatic do_load(input logic [7:0] v, output int busy_cycles);
        @(negedge clk);
        load = 1'b1;
        data = v;
        @(negedge clk);
        load = 1'b0;
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            data = 8'($urandom);
            load = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        load = 1'b0;
        disp_val = int'($signed(v));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load = 1'b0;
        data = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || seg !== 8'hFF || an !== 4'hF) begin
            errors++;
            $display("FAIL reset_state: busy=%b seg=%h an=%b required 0 FF 1111", busy, seg, an);
        end
        rst = 1'b0;
        disp_val = 0;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_first_edge: an=%b seg=%h required 1110 C0", an, seg);
        end
    endtask

    task automatic test_scan(input string name);
        logic [3:0] ea;
        logic [7:0] es;
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (cyc == 0) begin
                ea = 4'hF;
                es = 8'hFF;
            end else begin
                ea = an_pattern(((cyc - 1) / 4) % 4);
                es = exp_glyph(((cyc - 1) / 4) % 4, disp_val);
            end
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL %s cycle %0d: an=%b seg=%h required %b %h", name, cyc, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_convert(input logic [7:0] v, input string name);
        int bc;
        do_load(v, bc);
        checks++;
        if (bc != 8) begin
            errors++;
            $display("FAIL %s busy_len: got %0d required 8", name, bc);
        end
        check_digits(name);
    endtask

    task automatic test_ignored_load();
        int bc;
        @(negedge clk);
        load = 1'b1;
        data = 8'h05;
        @(negedge clk);
        load = 1'b0;
        bc = 1;
        repeat (2) begin
            @(negedge clk);
            bc++;
        end
        load = 1'b1;
        data = 8'h09;
        @(negedge clk);
        bc++;
        load = 1'b0;
        while (busy === 1'b1 && bc < 20) begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
        end
        checks++;
        if (bc != 8) begin
            errors++;
            $display("FAIL ignored_load busy_len: got %0d required 8", bc);
        end
        disp_val = 5;
        check_digits("ignored_load");
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        load = 1'b1;
        data = 8'hD6;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL b2b first busy_len: got %0d required 8", n);
        end
        data = 8'h2A;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b reaccept: busy=%b required 1", busy);
        end
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL b2b second busy_len: got %0d required 8", n);
        end
        disp_val = 42;
        check_digits("b2b");
    endtask

    task automatic test_rst_abort();
        @(negedge clk);
        load = 1'b1;
        data = 8'h64;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort pre: busy=%b required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || seg !== 8'hFF || an !== 4'hF) begin
            errors++;
            $display("FAIL rst_abort async: busy=%b seg=%h an=%b required 0 FF 1111", busy, seg, an);
        end
        @(negedge clk);
        rst = 1'b0;
        disp_val = 0;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort idle: busy=%b required 0", busy);
        end
        check_digits("rst_abort_cleared");
        test_convert(8'hFF, "after_abort_m1");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        load = 1'b0;
        data = 8'h00;
        disp_val = 0;
        test_reset();
        test_scan("scan_zero");
        test_convert(8'h7B, "conv_123");
        test_scan("scan_123");
        test_convert(8'h80, "conv_m128");
        test_ignored_load();
        test_convert(8'h00, "conv_0");
        test_convert(8'h7F, "conv_127");
        for (int i = 0; i < 10; i++) begin
            test_convert(8'($urandom), "conv_rand");
        end
        test_back_to_back();
        test_rst_abort();
        test_scan("scan_m1");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
